// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the IITB-RISC instruction fetch stage.
// Build option: define IF_FETCH_BUF_EN for a 2-entry fetch buffer
// (prefetch continues through a 1-instruction stall); otherwise 1 entry.
package if_pkg;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] BUBBLE_IW = 16'hFFFE;

`ifdef IF_FETCH_BUF_EN
    localparam int unsigned FETCH_DEPTH = 2;
`else
    localparam int unsigned FETCH_DEPTH = 1;
`endif

    // Fetch sequencer states: ISSUE (may request), WAIT (response owed),
    // DRAIN (response owed but must be thrown away after a redirect).
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] iw;
    } fetch_entry_t;

    // Sequential fetch address; wraps 16'hFFFF -> 16'h0000 naturally.
    function automatic logic [15:0] pc_next(input logic [15:0] pc);
        return pc + 16'h0001;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bundle for the fetch stage.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;

    // Fetch unit side: issues requests, receives grant and response.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_buf.sv
// Small shift-style FIFO of {pc, iw} fetch entries. Entry 0 is always the
// head, so the head output needs no read pointer. Flush beats push and pop.
module if_fetch_buf
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    fetch_entry_t w_shift [DEPTH];
    logic [1:0]   r_count;
    logic [1:0]   w_count_nxt;
    logic [1:0]   w_wr_idx;
    logic         w_pop_ok;
    logic         w_push_ok;

    // Value each entry takes when the FIFO advances by one on a pop.
    for (genvar g = 0; g < DEPTH; g++) begin : g_shift
        if (g < DEPTH - 1) begin : g_mid
            assign w_shift[g] = r_mem[g + 1];
        end else begin : g_last
            assign w_shift[g] = r_mem[g];
        end
    end

    // Qualify push/pop against occupancy and pick the write slot.
    always_comb begin
        w_pop_ok  = i_pop && (r_count != 2'd0);
        w_push_ok = i_push && ((r_count < DEPTH_C) || w_pop_ok);
        if (w_pop_ok) begin
            w_wr_idx = r_count - 2'd1;
        end else begin
            w_wr_idx = r_count;
        end
    end

    // Next occupancy.
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Entry storage: write the pushed entry, otherwise shift on pop.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push_ok && (w_wr_idx == 2'(i))) begin
                    r_mem[i] <= i_push_entry;
                end else if (w_pop_ok) begin
                    r_mem[i] <= w_shift[i];
                end else begin
                    r_mem[i] <= r_mem[i];
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i];
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[0];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage of the 16-bit IITB-RISC pipeline: PC generation,
// single-outstanding imem handshake, fetch buffer and redirect flushing.
// Build option: IF_FETCH_BUF_EN selects a 2-entry buffer (default 1 entry).
module if_fetch_unit
    import if_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_resetn,
    if_fetch_unit_if.master   imem,
    input  logic              i_redirect,
    input  logic [15:0]       i_redirect_pc,
    input  logic              i_stall_IF,
    output logic [15:0]       o_out_IW,
    output logic [15:0]       o_out_pc,
    output logic              o_out_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [15:0]  r_fetch_pc;
    logic [15:0]  w_fetch_pc_nxt;
    logic [15:0]  r_req_pc;
    logic [15:0]  w_req_pc_nxt;
    logic [15:0]  r_pending_pc;
    logic [15:0]  w_pending_pc_nxt;

    logic         w_push;
    logic         w_flush;
    logic         w_pop;
    logic         w_slot_free;
    logic         w_req;
    logic         w_valid;
    logic [1:0]   w_count;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    if_fetch_buf #(
        .DEPTH (FETCH_DEPTH)
    ) u_buf (
        .i_clk        (i_clk),
        .i_resetn     (i_resetn),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .o_count      (w_count),
        .o_head       (w_head)
    );

    // Head is consumable whenever the buffer holds something and IF is not held.
    always_comb begin
        w_valid = (w_count != 2'd0);
        w_pop   = w_valid && !i_stall_IF;
    end

    // A request may go out only if its response is guaranteed a buffer slot.
`ifdef IF_FETCH_BUF_EN
    always_comb begin
        w_slot_free = (w_count < 2'(FETCH_DEPTH));
    end
`else
    always_comb begin
        w_slot_free = (w_count == 2'd0) || w_pop;
    end
`endif

    // Response is tagged with the address of the request that produced it.
    always_comb begin
        w_push_entry.pc = r_req_pc;
        w_push_entry.iw = imem.imem_rdata;
    end

    // Sequencer next-state and handshake decode; redirect overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_req_pc_nxt     = r_req_pc;
        w_pending_pc_nxt = r_pending_pc;
        w_push           = 1'b0;
        w_flush          = i_redirect;
        w_req            = 1'b0;
        case (r_state)
            ISSUE: begin
                w_req = w_slot_free;
                if (i_redirect) begin
                    w_fetch_pc_nxt = i_redirect_pc;
                    if (w_req && imem.imem_gnt) begin
                        // The granted request is stale; its response must be eaten.
                        w_pending_pc_nxt = i_redirect_pc;
                        w_state_nxt      = DRAIN;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end else if (w_req && imem.imem_gnt) begin
                    w_req_pc_nxt   = r_fetch_pc;
                    w_fetch_pc_nxt = pc_next(r_fetch_pc);
                    w_state_nxt    = WAIT;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            WAIT: begin
                if (i_redirect) begin
                    if (imem.imem_rvalid) begin
                        // Response lands with the redirect: drop it, nothing left owed.
                        w_fetch_pc_nxt = i_redirect_pc;
                        w_state_nxt    = ISSUE;
                    end else begin
                        w_pending_pc_nxt = i_redirect_pc;
                        w_state_nxt      = DRAIN;
                    end
                end else if (imem.imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DRAIN: begin
                if (imem.imem_rvalid) begin
                    if (i_redirect) begin
                        w_fetch_pc_nxt = i_redirect_pc;
                    end else begin
                        w_fetch_pc_nxt = r_pending_pc;
                    end
                    w_state_nxt = ISSUE;
                end else if (i_redirect) begin
                    w_pending_pc_nxt = i_redirect_pc;
                    w_state_nxt      = DRAIN;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_flush     = 1'b1;
                w_state_nxt = ISSUE;
            end
        endcase
    end

    // Sequencer and PC registers.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state      <= ISSUE;
            r_fetch_pc   <= RESET_PC;
            r_req_pc     <= 16'h0000;
            r_pending_pc <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_req_pc     <= w_req_pc_nxt;
            r_pending_pc <= w_pending_pc_nxt;
        end
    end

    // Drive the memory side; no request may leak out while reset is held.
    always_comb begin
        imem.imem_req  = w_req && i_resetn;
        imem.imem_addr = r_fetch_pc;
    end

    // IF/ID presentation: buffer head or a bubble.
    always_comb begin
        o_out_valid = w_valid;
        if (w_valid) begin
            o_out_IW = w_head.iw;
            o_out_pc = w_head.pc;
        end else begin
            o_out_IW = BUBBLE_IW;
            o_out_pc = 16'h0000;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + randomised bench for if_fetch_unit with a behavioural memory and
// a scoreboard queue that mirrors the expected fetch buffer contents.
module tb_if_fetch_unit;

`ifdef IF_FETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        resetn;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [15:0] out_IW;
    logic [15:0] out_pc;
    logic        out_valid;

    if_fetch_unit_if imem ();

    if_fetch_unit dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .imem          (imem.master),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_stall_IF    (stall),
        .o_out_IW      (out_IW),
        .o_out_pc      (out_pc),
        .o_out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // memory / model state
    logic        gnt_en;
    int          latency;
    logic        busy;
    int          lat;
    logic [15:0] resp_addr;
    int          resp_epoch;
    int          epoch;
    logic [15:0] exp_addr;
    logic [31:0] exp_q [$];

    function automatic logic [15:0] iw_of(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory, check outputs, advance model past the edge.
    task automatic tick();
        logic        s_req;
        logic [15:0] s_addr;
        logic        s_rv;
        logic        s_pop;
        logic        s_free;
        int          e0;
        imem.imem_gnt    = gnt_en;
        s_rv             = resetn && busy && (lat == 0);
        imem.imem_rvalid = s_rv;
        imem.imem_rdata  = s_rv ? iw_of(resp_addr) : 16'h0000;
        #1;
        s_req  = imem.imem_req;
        s_addr = imem.imem_addr;
        s_pop  = 1'b0;
        if (!resetn) begin
            chk("rst_req",   32'(s_req),     32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_IW",    32'(out_IW),    32'h0000FFFE);
            chk("rst_pc",    32'(out_pc),    32'd0);
        end else begin
            s_pop = (exp_q.size() > 0) && !stall;
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("out_pc", 32'(out_pc), 32'(exp_q[0][31:16]));
                chk("out_IW", 32'(out_IW), 32'(exp_q[0][15:0]));
            end else begin
                chk("bubble_pc", 32'(out_pc), 32'd0);
                chk("bubble_IW", 32'(out_IW), 32'h0000FFFE);
            end
            s_free = (exp_q.size() < DEPTH) || ((DEPTH == 1) && s_pop);
            chk("imem_req", 32'(s_req), 32'(!busy && s_free));
            if (s_req) begin
                chk("imem_addr", 32'(s_addr), 32'(exp_addr));
            end
        end
        @(posedge clk);
        if (!resetn) begin
            exp_q.delete();
            busy     = 1'b0;
            lat      = 0;
            exp_addr = 16'h0000;
        end else begin
            e0 = epoch;
            if (redirect) epoch++;
            if (s_pop) void'(exp_q.pop_front());
            if (s_rv) begin
                busy = 1'b0;
                if (resp_epoch == epoch) exp_q.push_back({resp_addr, iw_of(resp_addr)});
            end else if (busy) begin
                lat--;
            end
            if (s_req && gnt_en) begin
                busy       = 1'b1;
                resp_addr  = s_addr;
                lat        = latency - 1;
                resp_epoch = e0;
                if (!redirect) exp_addr = exp_addr + 16'd1;
            end
            if (redirect) begin
                exp_q.delete();
                exp_addr = redirect_pc;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until a response is outstanding with the given remaining latency.
    task automatic wait_lat(input int want);
        for (int i = 0; i < 30 && !(busy && lat == want); i++) tick();
        chk("wait_outstanding", 32'(busy && lat == want), 32'd1);
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        stall       = 1'b0;
        gnt_en      = 1'b1;
        latency     = 1;
        busy        = 1'b0;
        lat         = 0;
        resp_addr   = 16'h0000;
        resp_epoch  = 0;
        epoch       = 0;
        exp_addr    = 16'h0000;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 16'h0000;
        @(negedge clk);

        // reset, then free-running 1-cycle memory
        run(2);
        resetn = 1'b1;
        run(10);

        // stall for 4 cycles, then release
        stall = 1'b1;
        run(4);
        stall = 1'b0;
        run(8);

        // redirect while a 3-cycle response is outstanding
        latency = 3;
        run(4);
        wait_lat(2);
        do_redirect(16'h0040);
        latency = 1;
        run(10);

        // redirect coinciding with rvalid
        latency = 2;
        run(3);
        wait_lat(0);
        do_redirect(16'h1234);
        latency = 1;
        run(8);

        // two redirects while draining
        latency = 4;
        run(6);
        wait_lat(3);
        do_redirect(16'h0100);
        do_redirect(16'h0200);
        latency = 1;
        run(12);

        // sequential wrap at FFFF
        do_redirect(16'hFFFE);
        run(10);

        // grant withheld for a while, address must stay put
        gnt_en = 1'b0;
        run(4);
        gnt_en = 1'b1;
        run(4);

        // reset in the middle of an outstanding request
        latency = 3;
        run(4);
        wait_lat(2);
        resetn = 1'b0;
        run(2);
        resetn  = 1'b1;
        latency = 1;
        run(8);

        // randomised mix of stalls, grants, latencies and redirects
        for (int i = 0; i < 150; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            gnt_en      = ($urandom_range(0, 3) != 0);
            latency     = $urandom_range(1, 3);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            tick();
        end
        stall    = 1'b0;
        gnt_en   = 1'b1;
        redirect = 1'b0;
        latency  = 1;
        run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage of the 16-bit IITB-RISC pipeline. Generates the PC and drives a single-outstanding instruction-memory request/grant/response handshake. Buffers returned instruction words and presents them, with their PC and a validity bit, to the IF/ID pipeline register. Honours the downstream stall and flushes on branch/jump redirects from later stages.

## Interface
- RESET_PC, 16'h0000: first fetch address after reset.
- BUBBLE_IW, 16'hFFFE: instruction word presented when no valid instruction is available.
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  16  word address of the request.
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt).
- imem_rvalid  in  1  response valid.
  - Exactly one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_rdata  in  16  instruction word, valid with imem_rvalid.
- redirect  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  16  redirect target.
- stall_IF  in  1  downstream holds; do not pop.
- out_IW  out  16  instruction at buffer head, or BUBBLE_IW when empty.
- out_pc  out  16  PC of out_IW, or 16'h0000 when empty.
- out_valid  out  1  buffer head valid; drives in_Validity_IF_ID.

## Operation
- Registers:
  - fetch_pc: next address to request.
  - FSM.
  - fetch buffer: FIFO of {pc, iw}, depth DEPTH.
  - pending_target: latched redirect target used in DRAIN.
- FSM states:
  - ISSUE:
    - imem_req=1 and imem_addr=fetch_pc when the slot is free (buffer count + outstanding < DEPTH); otherwise imem_req=0.
    - On grant: fetch_pc <= fetch_pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000); go to WAIT.
  - WAIT: on imem_rvalid, push {request pc, imem_rdata} into the buffer and go to ISSUE.
  - DRAIN: entered on redirect while a response is outstanding. On imem_rvalid, discard the data, set fetch_pc <= pending_target, and go to ISSUE.
- Pop: head removed on a cycle with out_valid=1 and stall_IF=0. Push and pop in the same cycle are both allowed.
- Redirect has priority over push, pop, stall and grant:
  - Buffer is emptied.
  - ISSUE: fetch_pc <= redirect_pc. A grant in the same cycle is ignored for sequencing; that request's response must be discarded, so go to DRAIN with pending_target = redirect_pc.
  - WAIT: go to DRAIN with pending_target = redirect_pc. A response arriving in the same cycle is discarded; fetch_pc <= redirect_pc and go directly to ISSUE.
  - DRAIN: pending_target overwritten; the latest redirect wins.
- imem_addr may change while imem_req is held without a grant only as a result of a redirect.

## Timing
- Reset:
  - fetch_pc=RESET_PC, FSM=ISSUE, buffer empty.
  - imem_req=0 during reset; first request in the first cycle after resetn=1.
  - out_valid=0, out_IW=BUBBLE_IW, out_pc=16'h0000.
- Reset asserted mid-transaction: all state cleared. The bench must not deliver a stale rvalid after reset.
- Response to output: imem_rvalid at cycle M gives out_valid=1 at M+1.
- Redirect to request: redirect at N with nothing outstanding gives imem_req with imem_addr=redirect_pc at N+1.
- Redirect to outputs: out_valid=0 from N+1 until a new response arrives.
- Throughput: one instruction per 2 cycles with a 1-cycle-latency memory (single outstanding request).
- Buffer full: no request issued. Buffer empty: out_IW=BUBBLE_IW, out_valid=0.

## Configuration
- IF_FETCH_BUF_EN defined: DEPTH=2. Prefetching continues through a 1-instruction stall.
- IF_FETCH_BUF_EN undefined: DEPTH=1. A new request is issued only when the single entry is empty, or is being popped in the same cycle.

## Structure
- Package if_pkg:
  - RESET_PC and BUBBLE_IW defaults.
  - FSM state enum (ISSUE, WAIT, DRAIN).
  - fetch entry struct {pc[15:0], iw[15:0]}.
- Sub-module if_fetch_buf: the DEPTH-entry FIFO with push, pop, flush, count, and head outputs.

## Test plan
- Reset then free-running 1-cycle memory, no stall -> addresses 0000,0001,0002 requested; out_pc sequence 0000,0001,0002 with matching out_IW.
- stall_IF=1 for 4 cycles with IF_FETCH_BUF_EN -> at most 2 entries buffered; imem_req=0 when full; no instruction lost or duplicated after release.
- Redirect to 16'h0040 while a response is outstanding (rvalid 3 cycles later) -> that response discarded; next imem_addr=0040; first out_pc=0040.
- Redirect in the same cycle as imem_rvalid -> data dropped; imem_addr=redirect_pc next cycle; out_valid=0 next cycle.
- Two redirects (0100 then 0200) during DRAIN -> only 0200 fetched.
- fetch_pc=FFFF with sequential fetch -> next imem_addr=0000.
